// File: rtl/msh_link_crdt_ctrl.sv
// msh_link_crdt_ctrl
//   Credit controller for the mesh link channels (wr_req / rd_req / rd_rsp
//   planes) at a mesh node boundary. Credits are held either in one counter
//   per channel (SHARED=0) or in a single pool arbitrated round-robin
//   (SHARED=1). An init/flush sequence lets a mesh edge be drained and
//   re-credited without a reset.
//
// Ports
//   mclk          mesh clock
//   i_reset       asynchronous reset, active-high
//   i_en          start init (sampled in IDLE)
//   i_flush       start flush (sampled in ACTIVE)
//   i_init_crdts  credits loaded per counter (pool value when SHARED=1)
//   i_req         per-channel send request
//   i_crdt_rtn    per-channel credit return, one credit per pulse
//   o_gnt         per-channel send grant, consumes one credit
//   o_crdt_cnt    current counts, CW bits per channel (pool in slice 0 when SHARED=1)
//   o_active      controller is in ACTIVE
//   o_flush_done  one-cycle pulse on the return to IDLE after a flush
//   o_ovf_err     sticky per-channel error for returns that could not be absorbed
module msh_link_crdt_ctrl #(
    parameter int NUM_CHAN  = 4,
    parameter int MAX_CRDTS = 8,
    parameter int SHARED    = 0,
    parameter int CW        = $clog2(MAX_CRDTS + 1)
) (
    input  logic                   mclk,
    input  logic                   i_reset,
    input  logic                   i_en,
    input  logic                   i_flush,
    input  logic [CW-1:0]          i_init_crdts,
    input  logic [NUM_CHAN-1:0]    i_req,
    input  logic [NUM_CHAN-1:0]    i_crdt_rtn,
    output logic [NUM_CHAN-1:0]    o_gnt,
    output logic [NUM_CHAN*CW-1:0] o_crdt_cnt,
    output logic                   o_active,
    output logic                   o_flush_done,
    output logic [NUM_CHAN-1:0]    o_ovf_err
);

    localparam int PW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    // Pool arithmetic width: count plus room for NUM_CHAN simultaneous returns.
    localparam int WW = CW + ((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 0) + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_CRDTS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_ACTIVE,
        ST_FLUSH
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt     [NUM_CHAN];
    logic [CW-1:0]       cnt_nxt [NUM_CHAN];
    logic [CW-1:0]       loaded;
    logic [PW-1:0]       rr_ptr;
    logic                flush_done_q;
    logic [NUM_CHAN-1:0] ovf_q;

    logic [NUM_CHAN-1:0] gnt;
    logic                rr_hit;
    logic [PW-1:0]       rr_sel;
    logic [PW:0]         rr_pos;
    logic [NUM_CHAN-1:0] ovf_set;
    logic [WW-1:0]       pool_sum;
    logic                all_full;
    logic [CW-1:0]       init_val;

    function automatic logic [CW-1:0] clamp_init(input logic [CW-1:0] v);
        return (v > MAX_C) ? MAX_C : v;
    endfunction

    function automatic logic [WW-1:0] popcount(input logic [NUM_CHAN-1:0] v);
        logic [WW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CHAN; i++) n = n + WW'(v[i]);
        return n;
    endfunction

    // Saturate the wide pool sum at the loaded credit value.
    function automatic logic [CW-1:0] sat_pool(input logic [WW-1:0] sum,
                                               input logic [CW-1:0] lim);
        return (sum > WW'(lim)) ? lim : sum[CW-1:0];
    endfunction

    assign init_val = clamp_init(i_init_crdts);

    // Grant decode from registered state and counts.
    always_comb begin
        gnt    = '0;
        rr_hit = 1'b0;
        rr_sel = '0;
        rr_pos = '0;
        if (state == ST_ACTIVE) begin
            if (SHARED != 0) begin
                if (cnt[0] != '0) begin
                    for (int k = 0; k < NUM_CHAN; k++) begin
                        rr_pos = {1'b0, rr_ptr} + (PW+1)'(k);
                        if (rr_pos >= (PW+1)'(NUM_CHAN)) rr_pos = rr_pos - (PW+1)'(NUM_CHAN);
                        if (!rr_hit && i_req[rr_pos[PW-1:0]]) begin
                            rr_hit                 = 1'b1;
                            rr_sel                 = rr_pos[PW-1:0];
                            gnt[rr_pos[PW-1:0]]    = 1'b1;
                        end
                    end
                end
            end else begin
                for (int c = 0; c < NUM_CHAN; c++) gnt[c] = i_req[c] && (cnt[c] != '0);
            end
        end
    end

    // Next counts and overflow flags; returns outside ACTIVE/FLUSH are errors.
    always_comb begin
        cnt_nxt  = cnt;
        ovf_set  = '0;
        pool_sum = '0;
        if (state == ST_ACTIVE || state == ST_FLUSH) begin
            if (SHARED != 0) begin
                pool_sum   = WW'(cnt[0]) - WW'(|gnt) + popcount(i_crdt_rtn);
                cnt_nxt[0] = sat_pool(pool_sum, loaded);
                if (pool_sum > WW'(loaded)) ovf_set = i_crdt_rtn;
            end else begin
                for (int c = 0; c < NUM_CHAN; c++) begin
                    if (i_crdt_rtn[c] && !gnt[c] && (cnt[c] == loaded))
                        ovf_set[c] = 1'b1;
                    else
                        cnt_nxt[c] = cnt[c] - CW'(gnt[c]) + CW'(i_crdt_rtn[c]);
                end
            end
        end else begin
            ovf_set = i_crdt_rtn;
        end
    end

    always_comb begin
        all_full = 1'b1;
        if (SHARED != 0) begin
            all_full = (cnt[0] == loaded);
        end else begin
            for (int c = 0; c < NUM_CHAN; c++)
                if (cnt[c] != loaded) all_full = 1'b0;
        end
    end

    always_ff @(posedge mclk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            loaded       <= '0;
            rr_ptr       <= '0;
            flush_done_q <= 1'b0;
            ovf_q        <= '0;
            for (int c = 0; c < NUM_CHAN; c++) cnt[c] <= '0;
        end else begin
            flush_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ovf_q <= ovf_q | ovf_set;
                    if (i_en) begin
                        state <= ST_INIT;
                        ovf_q <= '0;
                    end
                end
                ST_INIT: begin
                    // The clear wins over any return seen during init.
                    ovf_q  <= '0;
                    loaded <= init_val;
                    for (int c = 0; c < NUM_CHAN; c++)
                        cnt[c] <= (SHARED == 0 || c == 0) ? init_val : '0;
                    state  <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    cnt   <= cnt_nxt;
                    ovf_q <= ovf_q | ovf_set;
                    if (rr_hit)
                        rr_ptr <= (rr_sel == PW'(NUM_CHAN - 1)) ? '0 : rr_sel + PW'(1);
                    if (i_flush) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    cnt   <= cnt_nxt;
                    ovf_q <= ovf_q | ovf_set;
                    if (all_full) begin
                        flush_done_q <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_crdt_cnt = '0;
        for (int c = 0; c < NUM_CHAN; c++) o_crdt_cnt[c*CW +: CW] = cnt[c];
    end

    assign o_gnt        = gnt;
    assign o_active     = (state == ST_ACTIVE);
    assign o_flush_done = flush_done_q;
    assign o_ovf_err    = ovf_q;

endmodule

// File: tb/tb_msh_link_crdt_ctrl.sv
module tb_msh_link_crdt_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, flush = 1'b0;
    logic [3:0]  init = '0, req = '0, rtn = '0;

    logic [3:0]  p_gnt, s_gnt, p_ovf, s_ovf;
    logic [15:0] p_cnt, s_cnt;
    logic        p_act, s_act, p_done, s_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    msh_link_crdt_ctrl #(.NUM_CHAN(4), .MAX_CRDTS(8), .SHARED(0)) u_priv (
        .mclk(clk), .i_reset(rst), .i_en(en), .i_flush(flush), .i_init_crdts(init),
        .i_req(req), .i_crdt_rtn(rtn), .o_gnt(p_gnt), .o_crdt_cnt(p_cnt),
        .o_active(p_act), .o_flush_done(p_done), .o_ovf_err(p_ovf));

    msh_link_crdt_ctrl #(.NUM_CHAN(4), .MAX_CRDTS(8), .SHARED(1)) u_shr (
        .mclk(clk), .i_reset(rst), .i_en(en), .i_flush(flush), .i_init_crdts(init),
        .i_req(req), .i_crdt_rtn(rtn), .o_gnt(s_gnt), .o_crdt_cnt(s_cnt),
        .o_active(s_act), .o_flush_done(s_done), .o_ovf_err(s_ovf));

    typedef struct {
        logic       en, flush;
        logic [3:0] init, req, rtn;
        logic [3:0] gnt;
        logic [15:0] cnt;
        logic       act, done;
        logic [3:0] ovf;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic f, input logic [3:0] in,
                                input logic [3:0] rq, input logic [3:0] rt,
                                input logic [3:0] g, input logic [15:0] c,
                                input logic a, input logic d, input logic [3:0] o);
        vec_t v;
        v.en = e; v.flush = f; v.init = in; v.req = rq; v.rtn = rt;
        v.gnt = g; v.cnt = c; v.act = a; v.done = d; v.ovf = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic e, input logic f, input logic [3:0] in,
                         input logic [3:0] rq, input logic [3:0] rt);
        @(negedge clk);
        en = e; flush = f; init = in; req = rq; rtn = rt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 0; flush = 0; init = 0; req = 0; rtn = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[$];

        // PRIVATE mode walk: init 3, drain ch0 and ch1, overflow, flush, re-init.
        //              en f  init  req    rtn    gnt    cnt       act done ovf
        tbl.push_back(mk(0,0,4'd0,4'h0,4'h0, 4'h0,16'h0000,0,0,4'h0)); // 0 reset state
        tbl.push_back(mk(1,0,4'd3,4'h0,4'h0, 4'h0,16'h0000,0,0,4'h0)); // 1 IDLE, en
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h0, 4'h0,16'h0000,0,0,4'h0)); // 2 INIT
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h0, 4'h1,16'h3333,1,0,4'h0)); // 3
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h0, 4'h1,16'h3332,1,0,4'h0)); // 4
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h0, 4'h1,16'h3331,1,0,4'h0)); // 5
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h0, 4'h0,16'h3330,1,0,4'h0)); // 6 ch0 empty
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h0, 4'h0,16'h3330,1,0,4'h0)); // 7
        tbl.push_back(mk(0,0,4'd3,4'h2,4'h0, 4'h2,16'h3330,1,0,4'h0)); // 8
        tbl.push_back(mk(0,0,4'd3,4'h2,4'h0, 4'h2,16'h3320,1,0,4'h0)); // 9
        tbl.push_back(mk(0,0,4'd3,4'h2,4'h0, 4'h2,16'h3310,1,0,4'h0)); // 10
        tbl.push_back(mk(0,0,4'd3,4'h2,4'h2, 4'h0,16'h3300,1,0,4'h0)); // 11 req+rtn at 0
        tbl.push_back(mk(0,0,4'd3,4'h2,4'h0, 4'h2,16'h3310,1,0,4'h0)); // 12 granted next
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h0, 4'h0,16'h3300,1,0,4'h0)); // 13
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h4, 4'h0,16'h3300,1,0,4'h0)); // 14 rtn at full
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h0, 4'h0,16'h3300,1,0,4'h4)); // 15 sticky
        tbl.push_back(mk(0,0,4'd3,4'h4,4'h4, 4'h4,16'h3300,1,0,4'h4)); // 16 gnt+rtn
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h0, 4'h0,16'h3300,1,0,4'h4)); // 17 unchanged
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h3, 4'h0,16'h3300,1,0,4'h4)); // 18
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h3, 4'h0,16'h3311,1,0,4'h4)); // 19
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h3, 4'h0,16'h3322,1,0,4'h4)); // 20
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h0, 4'h1,16'h3333,1,0,4'h4)); // 21
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h0, 4'h1,16'h3332,1,0,4'h4)); // 22
        tbl.push_back(mk(0,1,4'd3,4'h0,4'h0, 4'h0,16'h3331,1,0,4'h4)); // 23 flush req
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h0, 4'h0,16'h3331,0,0,4'h4)); // 24 FLUSH, no gnt
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h1, 4'h0,16'h3331,0,0,4'h4)); // 25
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h1, 4'h0,16'h3332,0,0,4'h4)); // 26
        tbl.push_back(mk(0,0,4'd3,4'h1,4'h0, 4'h0,16'h3333,0,0,4'h4)); // 27 all full
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h0, 4'h0,16'h3333,0,1,4'h4)); // 28 done pulse
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h0, 4'h0,16'h3333,0,0,4'h4)); // 29 pulse gone
        tbl.push_back(mk(0,0,4'd3,4'h0,4'h8, 4'h0,16'h3333,0,0,4'h4)); // 30 rtn in IDLE
        tbl.push_back(mk(1,0,4'd3,4'h0,4'h0, 4'h0,16'h3333,0,0,4'hC)); // 31 en
        tbl.push_back(mk(0,0,4'd12,4'h0,4'h1,4'h0,16'h3333,0,0,4'h0)); // 32 INIT, clamp
        tbl.push_back(mk(0,0,4'd12,4'h0,4'h0,4'h0,16'h8888,1,0,4'h0)); // 33

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].flush, tbl[i].init, tbl[i].req, tbl[i].rtn);
            chk($sformatf("row%0d gnt", i),  {12'd0, p_gnt}, {12'd0, tbl[i].gnt});
            chk($sformatf("row%0d cnt", i),  p_cnt,          tbl[i].cnt);
            chk($sformatf("row%0d act", i),  {15'd0, p_act}, {15'd0, tbl[i].act});
            chk($sformatf("row%0d done", i), {15'd0, p_done},{15'd0, tbl[i].done});
            chk($sformatf("row%0d ovf", i),  {12'd0, p_ovf}, {12'd0, tbl[i].ovf});
        end

        // SHARED pool: round-robin order, pool accounting, overflow saturation.
        do_reset();
        drive(1, 0, 4'd8, 4'h0, 4'h0);
        drive(0, 0, 4'd8, 4'h0, 4'h0);
        drive(0, 0, 4'd8, 4'hF, 4'h0);
        chk("shr rr0 gnt", {12'd0, s_gnt}, 16'h0001); chk("shr rr0 pool", s_cnt, 16'h0008);
        drive(0, 0, 4'd8, 4'hF, 4'h0);
        chk("shr rr1 gnt", {12'd0, s_gnt}, 16'h0002); chk("shr rr1 pool", s_cnt, 16'h0007);
        drive(0, 0, 4'd8, 4'hF, 4'h0);
        chk("shr rr2 gnt", {12'd0, s_gnt}, 16'h0004); chk("shr rr2 pool", s_cnt, 16'h0006);
        drive(0, 0, 4'd8, 4'hF, 4'h0);
        chk("shr rr3 gnt", {12'd0, s_gnt}, 16'h0008); chk("shr rr3 pool", s_cnt, 16'h0005);
        drive(0, 0, 4'd8, 4'h0, 4'h0);
        chk("shr pool4", s_cnt, 16'h0004); chk("shr idle gnt", {12'd0, s_gnt}, 16'h0000);
        drive(0, 0, 4'd8, 4'hF, 4'h0);
        chk("shr wrap gnt", {12'd0, s_gnt}, 16'h0001);
        drive(0, 0, 4'd8, 4'h0, 4'hF);
        chk("shr pool3", s_cnt, 16'h0003);
        drive(0, 0, 4'd8, 4'h0, 4'h6);
        chk("shr pool7", s_cnt, 16'h0007); chk("shr ovf pre", {12'd0, s_ovf}, 16'h0000);
        drive(0, 0, 4'd8, 4'h4, 4'h4);
        chk("shr sat pool", s_cnt, 16'h0008); chk("shr ovf", {12'd0, s_ovf}, 16'h0006);
        chk("shr rr from1 gnt", {12'd0, s_gnt}, 16'h0004);
        drive(0, 0, 4'd8, 4'hF, 4'h0);
        chk("shr gnt+rtn pool", s_cnt, 16'h0008); chk("shr rr3b gnt", {12'd0, s_gnt}, 16'h0008);

        // Zero credits: never grants, flush completes on the first FLUSH cycle.
        do_reset();
        drive(1, 0, 4'd0, 4'h0, 4'h0);
        drive(0, 0, 4'd0, 4'h0, 4'h0);
        drive(0, 1, 4'd0, 4'hF, 4'h0);
        chk("zero act", {15'd0, p_act}, 16'h0001);
        chk("zero pgnt", {12'd0, p_gnt}, 16'h0000); chk("zero sgnt", {12'd0, s_gnt}, 16'h0000);
        drive(0, 0, 4'd0, 4'hF, 4'h0);
        chk("zero flush act", {15'd0, p_act}, 16'h0000); chk("zero flush done", {15'd0, p_done}, 16'h0000);
        drive(0, 0, 4'd0, 4'h0, 4'h0);
        chk("zero done", {15'd0, p_done}, 16'h0001); chk("zero sdone", {15'd0, s_done}, 16'h0001);

        // Asynchronous reset mid-FLUSH with credits outstanding, then re-init.
        do_reset();
        drive(1, 0, 4'd5, 4'h0, 4'h0);
        drive(0, 0, 4'd5, 4'h0, 4'h0);
        drive(0, 0, 4'd5, 4'h1, 4'h0);
        drive(0, 0, 4'd5, 4'h1, 4'h0);
        drive(0, 1, 4'd5, 4'h0, 4'h0);
        drive(0, 0, 4'd5, 4'h1, 4'h0);
        chk("mid flush cnt", p_cnt, 16'h5553); chk("mid flush gnt", {12'd0, p_gnt}, 16'h0000);
        #2 rst = 1'b1;
        #1;
        chk("async rst cnt", p_cnt, 16'h0000); chk("async rst act", {15'd0, p_act}, 16'h0000);
        chk("async rst gnt", {12'd0, p_gnt}, 16'h0000); chk("async rst ovf", {12'd0, p_ovf}, 16'h0000);
        chk("async rst scnt", s_cnt, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 4'd5, 4'h0, 4'h0);
        drive(0, 0, 4'd5, 4'h0, 4'h0);
        drive(0, 0, 4'd5, 4'h0, 4'h0);
        chk("reinit cnt", p_cnt, 16'h5555); chk("reinit act", {15'd0, p_act}, 16'h0001);
        chk("reinit pool", s_cnt, 16'h0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
